// File: rtl/fir_output_decimator.sv
// fir_output_decimator
//   Decimates the FIR output stream by DECIM, requantizes each kept sample
//   (round-half-up, arithmetic right shift by SHIFT, saturate to OUT_W bits)
//   and buffers results in a show-ahead FIFO with a valid/ready output.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   in_data carries a new FIR sample
//   in_data    signed FIR sample (IN_W bits)
//   out_valid  FIFO not empty, out_data valid
//   out_ready  downstream accepts out_data this cycle
//   out_data   signed requantized sample at FIFO head (OUT_W bits)
//   sat_pulse  the sample just captured in the quant register was clipped
//   overflow   sticky: a sample was dropped on a full FIFO
//   level      current FIFO occupancy
module fir_output_decimator #(
    parameter int unsigned IN_W       = 32,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SHIFT      = 15,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic signed [IN_W-1:0]          in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [OUT_W-1:0]         out_data,
    output logic                            sat_pulse,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned EXT_W = IN_W + 1;

    localparam logic signed [EXT_W-1:0] RND     = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);

    // ---------------- decimation ----------------
    logic [PH_W-1:0] phase_q, phase_d;
    logic            keep;

    always_comb begin
        phase_d = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
        end
    end

    assign keep = in_valid && (phase_q == '0);

    // ---------------- requantize ----------------
    // One extra bit of headroom so adding the rounding constant never wraps.
    logic signed [EXT_W-1:0] ext, rounded, shifted;
    logic signed [OUT_W-1:0] q_data_d;
    logic                    clip;

    always_comb begin
        ext      = {in_data[IN_W-1], in_data};
        rounded  = ext + RND;
        shifted  = rounded >>> SHIFT;
        clip     = 1'b0;
        q_data_d = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            q_data_d = SAT_MAX[OUT_W-1:0];
            clip     = 1'b1;
        end else if (shifted < SAT_MIN) begin
            q_data_d = SAT_MIN[OUT_W-1:0];
            clip     = 1'b1;
        end
    end

    logic                    q_valid_q, sat_q;
    logic signed [OUT_W-1:0] q_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= '0;
            q_valid_q <= 1'b0;
            sat_q     <= 1'b0;
            q_data_q  <= '0;
        end else begin
            phase_q   <= phase_d;
            q_valid_q <= keep;
            sat_q     <= keep && clip;
            if (keep) begin
                q_data_q <= q_data_d;
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic signed [OUT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]          level_q;
    logic signed [OUT_W-1:0] last_q;
    logic                    ovf_q;
    logic                    full, empty, push, pop, drop;

    assign full  = (level_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign pop   = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = q_valid_q && (!full || pop);
    assign drop  = q_valid_q && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= q_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (PTR_W + 1)'(1);
                2'b01:   level_q <= level_q - (PTR_W + 1)'(1);
                default: level_q <= level_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // When empty, show the last popped value so stale RAM contents from before
    // a reset never reach the output.
    assign out_valid = !empty;
    assign out_data  = empty ? last_q : mem_q[rd_ptr_q];
    assign sat_pulse = sat_q;
    assign overflow  = ovf_q;
    assign level     = level_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Testbench for fir_output_decimator (DECIM=4). A cycle-level reference model
// computes expected samples with plain integer arithmetic and pushes accepted
// ones into a scoreboard queue; a negedge monitor compares the DUT against it.
module tb_fir_output_decimator;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned SHIFT = 15;
    localparam int unsigned DECIM = 4;
    localparam int unsigned DEPTH = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic signed [IN_W-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     sat_pulse;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   level;

    fir_output_decimator #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .SHIFT      (SHIFT),
        .DECIM      (DECIM),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_pulse (sat_pulse),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint sb[$];
    bit     started = 0;
    int     m_level;
    bit     m_pend;
    longint m_pend_val;
    bit     m_sat;
    bit     m_ovf;
    longint m_cnt;
    longint m_last;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // floor((v + 2^(SHIFT-1)) / 2^SHIFT), then clip to OUT_W signed range
    function automatic longint ref_quant(input longint v, output bit sat);
        longint scale, num, t, vmax, vmin;
        scale = longint'(1) << SHIFT;
        vmax  = (longint'(1) << (OUT_W - 1)) - 1;
        vmin  = -(longint'(1) << (OUT_W - 1));
        num   = v + scale / 2;
        if (num >= 0) t = num / scale;
        else          t = -((-num + scale - 1) / scale);
        sat = 1'b0;
        if (t > vmax) begin
            t = vmax; sat = 1'b1;
        end else if (t < vmin) begin
            t = vmin; sat = 1'b1;
        end
        return t;
    endfunction

    // Advance the model by one rising edge using the inputs applied for it.
    task automatic model_update();
        bit pop, push, s;
        if (reset) begin
            sb.delete();
            m_level = 0; m_pend = 0; m_sat = 0; m_ovf = 0; m_cnt = 0; m_last = 0;
            started = 1;
        end else begin
            pop  = (m_level > 0) && out_ready;
            push = 0;
            if (m_pend) begin
                if (m_level < DEPTH || pop) begin
                    push = 1;
                    sb.push_back(m_pend_val);
                end else begin
                    m_ovf = 1;
                end
            end
            m_level = m_level + int'(push) - int'(pop);
            m_pend  = 0;
            m_sat   = 0;
            if (in_valid) begin
                if (m_cnt % DECIM == 0) begin
                    m_pend     = 1;
                    m_pend_val = ref_quant(longint'(in_data), s);
                    m_sat      = s;
                end
                m_cnt++;
            end
        end
    endtask

    task automatic step(input bit iv, input logic [IN_W-1:0] d, input bit rdy, input bit rst);
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        reset     = rst;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Monitor: compare the DUT against the model half a cycle after each edge.
    always @(negedge clk) begin
        if (started) begin
            chk("level", longint'(level), longint'(m_level));
            chk("out_valid", longint'(out_valid), longint'(m_level > 0));
            chk("overflow", longint'(overflow), longint'(m_ovf));
            chk("sat_pulse", longint'(sat_pulse), longint'(m_sat));
            if (out_valid && sb.size() > 0) begin
                chk("out_data", longint'(out_data), sb[0]);
                if (out_ready) begin
                    m_last = sb[0];
                    void'(sb.pop_front());
                end
            end else if (!out_valid) begin
                chk("out_data_idle", longint'(out_data), m_last);
            end
        end
    end

    // Value that exercises rounding and saturation edges
    function automatic logic [IN_W-1:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return IN_W'($signed($urandom_range(0, 2097152)) - 1048576);
            2:       return ($urandom_range(0, 1) != 0) ? 32'h7fff_ffff : 32'h8000_0000;
            default: return IN_W'(($signed($urandom_range(0, 200)) - 100) * 16384
                                  + $signed($urandom_range(0, 2)) - 1);
        endcase
    endfunction

    logic [IN_W-1:0] round_vals [6];
    logic [IN_W-1:0] sat_vals [3];
    int              drained;

    initial begin
        round_vals[0] = 32768;  round_vals[1] = 16384;   round_vals[2] = 16383;
        round_vals[3] = -16384; round_vals[4] = -16385;  round_vals[5] = 0;
        sat_vals[0] = 32'h7fff_ffff; sat_vals[1] = 32'h8000_0000; sat_vals[2] = 1073709056;

        in_valid = 0; in_data = '0; out_ready = 0; reset = 1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_level", longint'(level), 0);

        // Rounding and saturation: each value lands on phase 0.
        for (int i = 0; i < 6; i++) begin
            step(1, round_vals[i], 1, 0);
            for (int j = 0; j < 3; j++) step(1, rand_data(), 1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, sat_vals[i], 1, 0);
            for (int j = 0; j < 3; j++) step(1, rand_data(), 1, 0);
        end
        repeat (4) step(0, 0, 1, 0);

        // Decimation, continuous then with gaps.
        for (int k = 0; k < 16; k++) step(1, IN_W'(32768 * k), 1, 0);
        for (int k = 0; k < 16; k++) begin
            step(1, IN_W'(32768 * k), 1, 0);
            step(0, $urandom, 1, 0);
        end
        repeat (4) step(0, 0, 1, 0);

        // Full / overflow, then drain.
        step(0, 0, 0, 1);
        for (int i = 0; i < 40; i++) step(1, rand_data(), 0, 0);
        step(0, 0, 0, 0);
        chk("full_level", longint'(level), 8);
        chk("full_overflow", longint'(overflow), 1);
        drained = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) drained++;
            step(0, 0, 1, 0);
        end
        chk("drain_count", longint'(drained), 8);
        chk("drain_empty", longint'(out_valid), 0);

        // Reset mid-stream with level 5.
        for (int i = 0; i < 18; i++) step(1, rand_data(), 0, 0);
        chk("mid_level", longint'(level), 5);
        step(0, 0, 0, 1);
        chk("mid_rst_level", longint'(level), 0);
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_ovf", longint'(overflow), 0);
        step(1, IN_W'(32768 * 7), 1, 0);
        chk("lat_1cyc_valid", longint'(out_valid), 0);
        step(0, 0, 1, 0);
        chk("lat_2cyc_valid", longint'(out_valid), 1);
        chk("lat_2cyc_data", longint'(out_data), 7);
        repeat (3) step(0, 0, 1, 0);

        // Full with simultaneous push and pop.
        step(0, 0, 0, 1);
        for (int i = 0; i < 33; i++) step(1, rand_data(), 0, 0);
        chk("pp_pre_level", longint'(level), 8);
        step(0, 0, 1, 0);
        chk("pp_level", longint'(level), 8);
        chk("pp_overflow", longint'(overflow), 0);
        repeat (12) step(0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 150) == 0);
        end
        repeat (12) step(0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
